// File: rtl/exponent_job_queue.sv
// Memory-mapped job dispatcher for the exponent core: queues (base, exponent)
// jobs, launches them one at a time over enable/ready, and buffers the products.
module exponent_job_queue #(
    parameter int JDEPTH = 4,
    parameter int RDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exp_select,
    input  logic        AS_L,
    input  logic        WE_L,
    input  logic [3:0]  addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        core_enable,
    output logic [31:0] core_x,
    output logic [31:0] core_a,
    input  logic [31:0] core_p,
    input  logic        core_ready,
    output logic        irq
);
    localparam int JAW = $clog2(JDEPTH);
    localparam int JCW = JAW + 1;
    localparam int RAW = $clog2(RDEPTH);
    localparam int RCW = RAW + 1;
    localparam logic [JCW-1:0] JFULL = JCW'(JDEPTH);
    localparam logic [RCW-1:0] RFULL = RCW'(RDEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_LO, S_WAIT_HI} state_t;

    state_t          state_q, state_d;
    logic            acc_q;
    logic [31:0]     base_q, base_d;
    logic            ovf_q, ovf_d, unf_q, unf_d;
    logic [31:0]     readdata_q, readdata_d;
    logic            core_en_q, core_en_d;
    logic [31:0]     core_x_q, core_x_d, core_a_q, core_a_d;
    logic            irq_q, irq_d;

    logic [31:0]     jx_mem_q [JDEPTH];
    logic [31:0]     ja_mem_q [JDEPTH];
    logic [JAW-1:0]  j_wp_q, j_wp_d, j_rp_q, j_rp_d;
    logic [JCW-1:0]  j_cnt_q, j_cnt_d;
    logic [31:0]     r_mem_q [RDEPTH];
    logic [RAW-1:0]  r_wp_q, r_wp_d, r_rp_q, r_rp_d;
    logic [RCW-1:0]  r_cnt_q, r_cnt_d;

    logic            acc, fire, bus_wr, bus_rd;
    logic            sel_base, sel_exp, sel_res, sel_stat;
    logic            j_full, launch, j_push, r_push, r_pop;
    logic [31:0]     status;

    always_comb begin
        acc      = exp_select & ~AS_L;
        fire     = acc & ~acc_q;
        bus_wr   = fire & ~WE_L;
        bus_rd   = fire & WE_L;
        sel_base = (addr == 4'h0);
        sel_exp  = (addr == 4'h4);
        sel_res  = (addr == 4'h8);
        sel_stat = (addr == 4'hC);

        j_full = (j_cnt_q == JFULL);
        launch = (state_q == S_IDLE) && (j_cnt_q != '0) && core_ready && (r_cnt_q < RFULL);
        // Full is judged on the pre-edge count, so a same-cycle launch does not rescue a push.
        j_push = bus_wr & sel_exp & ~j_full;
        r_push = (state_q == S_WAIT_HI) && core_ready;
        r_pop  = bus_rd & sel_res & (r_cnt_q != '0);

        j_wp_d  = j_wp_q + JAW'(j_push);
        j_rp_d  = j_rp_q + JAW'(launch);
        j_cnt_d = j_cnt_q + JCW'(j_push) - JCW'(launch);
        r_wp_d  = r_wp_q + RAW'(r_push);
        r_rp_d  = r_rp_q + RAW'(r_pop);
        r_cnt_d = r_cnt_q + RCW'(r_push) - RCW'(r_pop);

        status            = '0;
        status[0]         = j_full;
        status[1]         = (j_cnt_q == '0);
        status[2]         = (r_cnt_q != '0);
        status[3]         = (r_cnt_q == RFULL);
        status[4]         = (state_q != S_IDLE);
        status[5]         = ovf_q;
        status[6]         = unf_q;
        status[8 +: JCW]  = j_cnt_q;
        status[16 +: RCW] = r_cnt_q;

        base_d     = base_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        readdata_d = readdata_q;
        if (bus_wr && sel_base) base_d = writedata;
        if (bus_wr && sel_exp && j_full) ovf_d = 1'b1;
        if (bus_wr && sel_stat) begin
            if (writedata[5]) ovf_d = 1'b0;
            if (writedata[6]) unf_d = 1'b0;
        end
        if (bus_rd) begin
            case (addr)
                4'h0:    readdata_d = base_q;
                4'h8:    readdata_d = (r_cnt_q != '0) ? r_mem_q[r_rp_q] : 32'h0;
                4'hC:    readdata_d = status;
                default: readdata_d = 32'h0;
            endcase
            if (sel_res && (r_cnt_q == '0)) unf_d = 1'b1;
        end

        irq_d = (r_cnt_d != '0);
    end

    always_comb begin
        state_d   = state_q;
        core_en_d = 1'b0;
        core_x_d  = core_x_q;
        core_a_d  = core_a_q;
        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    core_en_d = 1'b1;
                    core_x_d  = jx_mem_q[j_rp_q];
                    core_a_d  = ja_mem_q[j_rp_q];
                    state_d   = S_WAIT_LO;
                end
            end
            S_WAIT_LO: if (!core_ready) state_d = S_WAIT_HI;
            S_WAIT_HI: if (core_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            acc_q      <= 1'b0;
            base_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            readdata_q <= '0;
            core_en_q  <= 1'b0;
            core_x_q   <= '0;
            core_a_q   <= '0;
            irq_q      <= 1'b0;
            j_wp_q     <= '0;
            j_rp_q     <= '0;
            j_cnt_q    <= '0;
            r_wp_q     <= '0;
            r_rp_q     <= '0;
            r_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc;
            base_q     <= base_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            readdata_q <= readdata_d;
            core_en_q  <= core_en_d;
            core_x_q   <= core_x_d;
            core_a_q   <= core_a_d;
            irq_q      <= irq_d;
            j_wp_q     <= j_wp_d;
            j_rp_q     <= j_rp_d;
            j_cnt_q    <= j_cnt_d;
            r_wp_q     <= r_wp_d;
            r_rp_q     <= r_rp_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    // Storage arrays need no reset: the counts alone define what is valid.
    always_ff @(posedge clk) begin
        if (j_push) begin
            jx_mem_q[j_wp_q] <= base_q;
            ja_mem_q[j_wp_q] <= writedata;
        end
        if (r_push) r_mem_q[r_wp_q] <= core_p;
    end

    assign readdata    = readdata_q;
    assign core_enable = core_en_q;
    assign core_x      = core_x_q;
    assign core_a      = core_a_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_exponent_job_queue.sv
// Bench for exponent_job_queue: behavioural core stand-in, queue-based reference
// model, per-cycle output compare, directed scenarios and a randomized phase.
module tb_exponent_job_queue;
    localparam int JDEPTH = 4;
    localparam int RDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exp_select = 1'b0, AS_L = 1'b1, WE_L = 1'b1;
    logic [3:0]  addr = 4'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata, core_x, core_a;
    logic        core_enable, irq;
    logic [31:0] core_p = 32'h0;
    logic        core_ready = 1'b1;

    always #5 clk = ~clk;

    exponent_job_queue #(.JDEPTH(JDEPTH), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .exp_select(exp_select), .AS_L(AS_L),
        .WE_L(WE_L), .addr(addr), .writedata(writedata), .readdata(readdata),
        .core_enable(core_enable), .core_x(core_x), .core_a(core_a),
        .core_p(core_p), .core_ready(core_ready), .irq(irq)
    );

    int n_cmp = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pow32(input logic [31:0] x, input logic [31:0] a);
        logic [31:0] r;
        r = 32'd1;
        for (int unsigned i = 0; i < a; i++) r = r * x;
        return r;
    endfunction

    // Reference model state
    logic [31:0] m_jx[$], m_ja[$], m_res[$];
    logic [31:0] m_base = 0, exp_rd = 0;
    bit          m_ovf = 0, m_unf = 0, m_inflight = 0;
    bit          done_pend = 0;
    logic [31:0] done_val = 0;
    bit          cpu_pend = 0, cpu_we = 0, cpu_sel = 0;
    logic [3:0]  cpu_addr = 0;
    logic [31:0] cpu_data = 0;
    int          mjc, mrc;
    bit          mbusy;
    bit          chk_en = 0, prev_cond = 0;
    bit          core_stall = 0, core_abort = 0;
    int          lat_lo = 1, lat_hi = 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_jx.delete(); m_ja.delete(); m_res.delete();
            m_base = 0; m_ovf = 0; m_unf = 0; m_inflight = 0;
            exp_rd = 0; done_pend = 0; cpu_pend = 0;
        end else begin
            mjc = m_jx.size(); mrc = m_res.size(); mbusy = m_inflight;
            if (cpu_pend) begin
                cpu_pend = 0;
                if (cpu_sel && cpu_we) begin
                    case (cpu_addr)
                        4'h0: m_base = cpu_data;
                        4'h4: begin
                            if (mjc == JDEPTH) m_ovf = 1;
                            else begin m_jx.push_back(m_base); m_ja.push_back(cpu_data); end
                        end
                        4'hC: begin
                            if (cpu_data[5]) m_ovf = 0;
                            if (cpu_data[6]) m_unf = 0;
                        end
                        default: ;
                    endcase
                end else if (cpu_sel) begin
                    case (cpu_addr)
                        4'h0: exp_rd = m_base;
                        4'h8: begin
                            if (mrc != 0) exp_rd = m_res.pop_front();
                            else begin exp_rd = 0; m_unf = 1; end
                        end
                        4'hC: exp_rd = {8'h0, 8'(mrc), 8'(mjc), 1'b0, m_unf, m_ovf, mbusy,
                                        mrc == RDEPTH, mrc != 0, mjc == 0, mjc == JDEPTH};
                        default: exp_rd = 0;
                    endcase
                end
            end
            if (done_pend) begin
                done_pend = 0;
                m_res.push_back(done_val);
                m_inflight = 0;
            end
        end
    end

    // Per-cycle compare: read data, irq, and every launch against the job queue.
    always begin
        @(negedge clk);
        #1;
        if (reset_n && chk_en) begin
            check("readdata", readdata, exp_rd);
            check("irq", {31'b0, irq}, {31'b0, m_res.size() != 0});
            check("core_enable", {31'b0, core_enable}, {31'b0, prev_cond});
            if (core_enable && m_jx.size() != 0) begin
                check("core_x", core_x, m_jx[0]);
                check("core_a", core_a, m_ja[0]);
                void'(m_jx.pop_front());
                void'(m_ja.pop_front());
                m_inflight = 1;
            end
            prev_cond = (m_jx.size() != 0) && !m_inflight && core_ready && (m_res.size() < RDEPTH);
        end else begin
            prev_cond = 0;
        end
    end

    // Behavioural exponent core
    logic [31:0] cx, ca;
    int          lat;
    always begin
        @(negedge clk);
        if (core_enable && reset_n) begin
            cx = core_x; ca = core_a;
            core_ready = 0;
            lat = $urandom_range(lat_hi, lat_lo);
            repeat (lat) @(negedge clk);
            while (core_stall && !core_abort) @(negedge clk);
            if (core_abort) begin
                core_abort = 0;
                core_ready = 1;
            end else begin
                core_p = pow32(cx, ca);
                core_ready = 1;
                done_val = core_p;
                done_pend = 1;
            end
        end
    end

    task automatic bus(input bit we, input logic [3:0] a, input logic [31:0] d,
                       input int hold, input bit sel);
        @(negedge clk);
        exp_select = sel; AS_L = 0; WE_L = !we; addr = a; writedata = d;
        cpu_we = we; cpu_addr = a; cpu_data = d; cpu_sel = sel; cpu_pend = 1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        exp_select = 0; AS_L = 1; WE_L = 1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1, a, d, 1, 1);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus(0, a, 32'h0, 1, 1);
        d = readdata;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_quiet();
        int i;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (!m_inflight && !done_pend && !core_enable && !prev_cond) break;
        end
        if (i == 300) begin
            n_cmp++; n_err++;
            $display("FAIL wait_quiet: timeout got busy expected idle at %0t", $time);
        end
    endtask

    initial begin
        logic [31:0] d;
        int op;
        repeat (3) @(negedge clk);
        #1;
        check("rst_readdata", readdata, 32'h0);
        check("rst_core_enable", {31'b0, core_enable}, 32'h0);
        check("rst_core_x", core_x, 32'h0);
        check("rst_core_a", core_a, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1; chk_en = 1;

        // Single job
        wr(4'h0, 3); wr(4'h4, 4);
        wait_quiet();
        check("single_irq", {31'b0, irq}, 32'h1);
        rd_chk("single_status", 4'hC, 32'h0001_0006);
        rd_chk("single_result", 4'h8, 32'd81);
        rd_chk("single_status2", 4'hC, 32'h0000_0002);

        // Queue of four
        wr(4'h0, 2); wr(4'h4, 10);
        wr(4'h0, 5); wr(4'h4, 0);
        wr(4'h0, 0); wr(4'h4, 3);
        wr(4'h0, 7); wr(4'h4, 2);
        wait_quiet();
        rd_chk("q4_r0", 4'h8, 32'd1024);
        rd_chk("q4_r1", 4'h8, 32'd1);
        rd_chk("q4_r2", 4'h8, 32'd0);
        rd_chk("q4_r3", 4'h8, 32'd49);

        // Overflow with core held not-ready
        @(negedge clk); core_ready = 0;
        wr(4'h0, 2);
        for (int i = 1; i <= 5; i++) wr(4'h4, i);
        rd_chk("ovf_status", 4'hC, 32'h0000_0421);
        wr(4'hC, 32'h20);
        rd_chk("ovf_cleared", 4'hC, 32'h0000_0401);
        @(negedge clk); core_ready = 1;
        wait_quiet();
        rd_chk("ovf_r0", 4'h8, 32'd2);
        rd_chk("ovf_r1", 4'h8, 32'd4);
        rd_chk("ovf_r2", 4'h8, 32'd8);
        rd_chk("ovf_r3", 4'h8, 32'd16);

        // Result-full back-pressure
        wr(4'h0, 3);
        for (int i = 0; i < 6; i++) wr(4'h4, i);
        wait_quiet();
        rd_chk("bp_status", 4'hC, 32'h0004_020C);
        rd_chk("bp_r0", 4'h8, 32'd1);
        wait_quiet();
        rd_chk("bp_status2", 4'hC, 32'h0004_010C);
        rd_chk("bp_r1", 4'h8, 32'd3);
        wait_quiet();
        rd_chk("bp_r2", 4'h8, 32'd9);
        rd_chk("bp_r3", 4'h8, 32'd27);
        rd_chk("bp_r4", 4'h8, 32'd81);
        rd_chk("bp_r5", 4'h8, 32'd243);

        // Underflow, wrap, held strobe
        rd_chk("unf_read", 4'h8, 32'h0);
        rd_chk("unf_status", 4'hC, 32'h0000_0042);
        wr(4'hC, 32'h40);
        rd_chk("unf_cleared", 4'hC, 32'h0000_0002);
        wr(4'h0, 32'h0001_0000); wr(4'h4, 2);
        wr(4'h0, 7); wr(4'h4, 3);
        wait_quiet();
        bus(0, 4'h8, 32'h0, 5, 1);
        check("wrap_result", readdata, 32'h0);
        rd_chk("held_status", 4'hC, 32'h0001_0006);
        rd_chk("held_r1", 4'h8, 32'd343);

        // Reset during WAIT_HI
        core_stall = 1;
        wr(4'h0, 3); wr(4'h4, 5); wr(4'h4, 6);
        repeat (4) @(negedge clk);
        rd_chk("mid_status", 4'hC, 32'h0000_0110);
        @(negedge clk);
        reset_n = 0; core_abort = 1;
        #1;
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_core_enable", {31'b0, core_enable}, 32'h0);
        check("mid_rst_core_x", core_x, 32'h0);
        check("mid_rst_core_a", core_a, 32'h0);
        check("mid_rst_irq", {31'b0, irq}, 32'h0);
        core_stall = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        rd_chk("post_rst_status", 4'hC, 32'h0000_0002);
        wr(4'h0, 2); wr(4'h4, 5);
        wait_quiet();
        rd_chk("post_rst_result", 4'h8, 32'd32);

        // Randomized traffic
        lat_lo = 1; lat_hi = 4;
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1: bus(1, 4'h0, $urandom, $urandom_range(1, 3), 1);
                2, 3: bus(1, 4'h4, $urandom_range(0, 12), $urandom_range(1, 3), 1);
                4, 5: bus(0, 4'h8, 32'h0, $urandom_range(1, 3), 1);
                6:    bus(0, 4'hC, 32'h0, $urandom_range(1, 3), 1);
                7:    bus(1, 4'hC, $urandom, 1, 1);
                8:    bus($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom,
                          $urandom_range(1, 3), $urandom_range(0, 1));
                default: repeat ($urandom_range(0, 3)) @(negedge clk);
            endcase
        end
        for (int n = 0; n < 40; n++) begin
            wait_quiet();
            if (m_res.size() == 0 && m_jx.size() == 0) break;
            rd(4'h8, d);
        end
        rd_chk("final_result_empty", 4'h8, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/exponent_job_queue.md
Name: exponent_job_queue

Overview:
- Bus-side dispatcher that feeds the `exponent` core and collects its results.
- The CPU writes (base, exponent) job pairs into a job FIFO. An FSM then launches each job on the core over its enable/ready handshake, captures each product `p` into a result FIFO, and the CPU pops results from that FIFO.
- Sits between the memory-mapped slave decode and the `exponent` core instance.

Parameters:
- JDEPTH, 4, job FIFO depth in (x,a) pairs; power of 2, ≥2.
- RDEPTH, 4, result FIFO depth in 32-bit words; power of 2, ≥2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset; shared with the `exponent` core
- exp_select  in  1  slave select from address decode
- AS_L  in  1  address strobe, active low
- WE_L  in  1  write enable, active low (0=write, 1=read)
- addr  in  4  byte offset within the slave
- writedata  in  32  CPU write data
- readdata  out  32  registered CPU read data
- core_enable  out  1  one-cycle launch pulse to the core
- core_x  out  32  base presented to the core
- core_a  out  32  exponent presented to the core
- core_p  in  32  product from the core
- core_ready  in  1  core ready
- irq  out  1  high while the result FIFO is non-empty

Behaviour:
- Reset (async, reset_n=0): both FIFOs empty, pointers and counts 0, FSM=IDLE, base_stage=0, sticky flags 0. Outputs: readdata=0, core_enable=0, core_x=0, core_a=0, irq=0.
- Access strobe: `acc = exp_select & ~AS_L`. An action fires only on the first cycle `acc` is high (rising-edge detect on a registered copy), so a held strobe acts exactly once.
- Register map (4-bit byte offsets):
  - 0x0 BASE: write loads base_stage. Read returns base_stage.
  - 0x4 EXP: write pushes {base_stage, writedata} into the job FIFO. If the job FIFO is full, the job is dropped and sticky ovf is set. Read returns 0.
  - 0x8 RESULT: read pops the result FIFO head into readdata. If empty, readdata=0 and sticky unf is set. Write is ignored.
  - 0xC STATUS: read bits are [0] job_full, [1] job_empty, [2] res_nonempty, [3] res_full, [4] busy (FSM≠IDLE), [5] ovf, [6] unf, [15:8] job_count, [23:16] res_count, others 0. Write: writedata[5]=1 clears ovf, writedata[6]=1 clears unf (W1C).
  - Any other offset: writes ignored, reads return 0.
- Read timing: readdata updates on the clock edge at which the strobe is detected and holds until the next read strobe.
- Dispatcher FSM:
  - IDLE: when job FIFO non-empty, core_ready=1 and res_count<RDEPTH:
    - pop job, drive core_x/core_a from it, pulse core_enable=1 for exactly one cycle;
    - go to WAIT_LO.
  - WAIT_LO: hold core_x/core_a; core_enable=0; on core_ready=0 go to WAIT_HI.
  - WAIT_HI: on the first cycle core_ready=1, push core_p into the result FIFO and go to IDLE.
  - The result-FIFO slot is guaranteed at launch because only one job is ever in flight.
- Minimum turnaround: the next launch may occur the cycle after IDLE is re-entered.
- Arithmetic is performed by the core, modulo 2^32; a=0 returns 1. This block does not alter p.
- Simultaneous events:
  - CPU push and dispatcher pop in the same cycle: both take effect, count unchanged.
  - Push while job_count=JDEPTH is dropped even if a pop occurs that cycle.
  - CPU result pop and core result push in the same cycle: both take effect.
- FIFOs wrap pointers modulo depth. Counts are $clog2(depth)+1 bits, zero-extended into the STATUS fields.
- irq = res_count≠0, registered.
- Reset mid-job: everything clears immediately, including the in-flight job. The core, on the same reset_n, returns to IDLE.

Test Plan:
- Single job: write BASE=3, EXP=4 → one core_enable pulse with core_x=3, core_a=4; STATUS[2]=1 and irq=1 after completion; RESULT read returns 81; STATUS then reads job_count=0, res_count=0.
- Queue of 4: jobs (2,10),(5,0),(0,3),(7,2) written back-to-back → launched in order, one at a time; results read in order 1024, 1, 0, 49.
- Overflow: with core held busy, write 5 EXPs (JDEPTH=4) → 5th dropped, ovf=1, job_count=4; STATUS write 0x20 clears ovf.
- Result full back-pressure: submit 6 jobs without reading → res_count stops at 4, job_count=2, no launch; one RESULT read → next job launches.
- Underflow and wrap: RESULT read on empty → readdata=0, unf=1. Then 2^16, 2^16 → result 0 (mod 2^32). A single read strobe held 5 cycles pops exactly once.
- Reset mid-job: deassert reset_n during WAIT_HI → all outputs 0 and FIFOs empty immediately; new job after release completes correctly.
